// File: rtl/load_store_unit.sv
// Load/store unit: bridges the execute stage to a handshaked data memory.
// It checks alignment, builds byte enables and lane-replicated store data,
// extends load data, stalls the PC during an access and times out stuck accesses.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  misalign,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  misalign_q, misalign_d;
    logic                  bus_err_q, bus_err_d;

    logic                  legal_c;
    logic [3:0]            be_c;
    logic [DATA_WIDTH-1:0] wdata_rep_c;
    logic [DATA_WIDTH-1:0] load_ext_c;
    logic [DATA_WIDTH-1:0] lane_c;

    // Legality of the incoming request: size vs address alignment, no unsigned stores.
    always_comb begin
        legal_c = 1'b0;
        case (req_funct3[1:0])
            2'b00:   legal_c = 1'b1;
            2'b01:   legal_c = ~req_addr[0];
            2'b10:   legal_c = (req_addr[1:0] == 2'b00);
            default: legal_c = 1'b0;
        endcase
        if (req_we && req_funct3[2]) begin
            legal_c = 1'b0;
        end
    end

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_c        = 4'b1111;
        wdata_rep_c = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_c        = 4'b0001 << req_addr[1:0];
                wdata_rep_c = DATA_WIDTH'({4{req_wdata[7:0]}});
            end
            2'b01: begin
                be_c        = 4'b0011 << req_addr[1:0];
                wdata_rep_c = DATA_WIDTH'({2{req_wdata[15:0]}});
            end
            default: begin
                be_c        = 4'b1111;
                wdata_rep_c = req_wdata;
            end
        endcase
    end

    // Shift the addressed lane down and sign/zero-extend it to a full word.
    always_comb begin
        lane_c     = mem_rdata >> {addr_q[1:0], 3'b000};
        load_ext_c = lane_c;
        case (f3_q[1:0])
            2'b00:   load_ext_c = f3_q[2] ? DATA_WIDTH'({24'd0, lane_c[7:0]})
                                          : DATA_WIDTH'({{24{lane_c[7]}}, lane_c[7:0]});
            2'b01:   load_ext_c = f3_q[2] ? DATA_WIDTH'({16'd0, lane_c[15:0]})
                                          : DATA_WIDTH'({{16{lane_c[15]}}, lane_c[15:0]});
            default: load_ext_c = lane_c;
        endcase
    end

    // Next-state logic: accept, wait for ack or timeout, report, return to idle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (legal_c) begin
                        we_d    = req_we;
                        f3_d    = req_funct3;
                        addr_d  = req_addr;
                        be_d    = be_c;
                        wdata_d = wdata_rep_c;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        load_data_d = load_ext_c;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    bus_err_d = 1'b1;
                    if (!we_q) begin
                        load_data_d = '0;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= '0;
            be_q        <= 4'd0;
            wdata_q     <= '0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Memory bus fields are only driven while a request is outstanding.
    always_comb begin
        mem_req   = (state_q == S_REQ);
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_be    = mem_req ? be_q : 4'd0;
        mem_wdata = mem_req ? wdata_q : '0;
    end

    // Pipeline-facing status.
    always_comb begin
        stall      = ((state_q == S_IDLE) & req_valid & legal_c) | (state_q == S_REQ);
        load_valid = (state_q == S_DONE) & ~we_q;
        load_data  = load_data_q;
        misalign   = misalign_q;
        bus_err    = bus_err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, corner sequences and random
// accesses checked against a behavioural model of the access rules.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_ld = 32'd0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        mis;
        int          stall_n;
        int          req_n;
        logic        buserr;
        int          lv_n;
        int          lv_cyc;
        logic [31:0] ld;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    typedef struct {
        int          mis_n;
        int          stall_n;
        int          req_n;
        int          be_n;
        int          lv_n;
        int          lv_cyc;
        logic [31:0] lv_data;
        logic [31:0] ld;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          unstable;
        int          leak;
    } obs_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        int          exp_stall;
        logic        exp_buserr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Outcome of one access derived from the architectural rules.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata, input int ack);
        exp_t        e;
        int          off;
        int          nbytes;
        logic [31:0] v;
        e = '{default: 0};
        off = int'(addr[1:0]);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.ld = model_ld;
        if (f3[1:0] == 2'd3 || (we && f3[2]) || (off % nbytes) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.req_n   = (ack < TO) ? ack + 1 : TO;
        e.buserr  = (ack >= TO);
        e.stall_n = 1 + e.req_n;
        e.addr    = addr - 32'(off);
        e.be      = 4'(((1 << nbytes) - 1) << off);
        e.wdata   = (nbytes == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                    (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
        e.we      = we;
        if (!we) begin
            e.lv_n   = 1;
            e.lv_cyc = e.req_n + 1;
            if (e.buserr) begin
                v = 32'd0;
            end else begin
                v = rdata >> (8 * off);
                if (nbytes == 1) begin
                    v = v % 32'd256;
                    if (!f3[2] && v >= 32'd128) v = v - 32'd256;
                end else if (nbytes == 2) begin
                    v = v % 32'd65536;
                    if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
                end
            end
            e.ld = v;
        end
        return e;
    endfunction

    // Issue one access and record what the unit does over a fixed window.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int ack,
                              output obs_t o);
        int req_seen;
        o = '{default: 0};
        req_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid  = (c == 0);
            req_we     = we;
            req_funct3 = f3;
            req_addr   = addr;
            req_wdata  = wdata;
            mem_rdata  = rdata;
            mem_ack    = mem_req && (req_seen == ack);
            #1;
            if (stall) o.stall_n++;
            if (misalign) o.mis_n++;
            if (bus_err) o.be_n++;
            if (load_valid) begin
                o.lv_n++;
                o.lv_cyc  = c;
                o.lv_data = load_data;
            end
            if (mem_req) begin
                if (req_seen == 0) begin
                    o.addr  = mem_addr;
                    o.be    = mem_be;
                    o.wdata = mem_wdata;
                    o.we    = mem_we;
                end else if (o.addr !== mem_addr || o.be !== mem_be ||
                             o.wdata !== mem_wdata || o.we !== mem_we) begin
                    o.unstable++;
                end
                req_seen++;
            end else if (mem_we !== 1'b0 || mem_be !== 4'd0 || mem_addr !== 32'd0 ||
                         mem_wdata !== 32'd0) begin
                o.leak++;
            end
        end
        o.req_n = req_seen;
        o.ld    = load_data;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic exercise(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ack, output obs_t o);
        exp_t e;
        e = model(we, f3, addr, wdata, rdata, ack);
        run_access(we, f3, addr, wdata, rdata, ack, o);
        chk({tag, " misalign"}, 32'(o.mis_n), 32'(e.mis));
        chk({tag, " stall"}, 32'(o.stall_n), 32'(e.stall_n));
        chk({tag, " req_cycles"}, 32'(o.req_n), 32'(e.req_n));
        chk({tag, " bus_err"}, 32'(o.be_n), 32'(e.buserr));
        chk({tag, " load_valid"}, 32'(o.lv_n), 32'(e.lv_n));
        if (e.lv_n != 0) begin
            chk({tag, " lv_cycle"}, 32'(o.lv_cyc), 32'(e.lv_cyc));
            chk({tag, " lv_data"}, o.lv_data, e.ld);
        end
        chk({tag, " load_data_hold"}, o.ld, e.ld);
        if (e.req_n != 0) begin
            chk({tag, " mem_addr"}, o.addr, e.addr);
            chk({tag, " mem_be"}, 32'(o.be), 32'(e.be));
            chk({tag, " mem_wdata"}, o.wdata, e.wdata);
            chk({tag, " mem_we"}, 32'(o.we), 32'(e.we));
            chk({tag, " req_stable"}, 32'(o.unstable), 32'd0);
        end
        chk({tag, " idle_bus_zero"}, 32'(o.leak), 32'd0);
        model_ld = e.ld;
    endtask

    vec_t vecs[12];
    obs_t o;
    int   n_lv;
    int   n_be;
    int   n_rq;

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFFFF80, 2, 1'b0};
        vecs[1]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 1'b0, 4'b1100, 32'h0, 32'h00008001, 2, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1'b0, 4'b1100, 32'h0, 32'hFFFF8001, 2, 1'b0};
        vecs[3]  = '{1'b1, 3'b000, 32'h021, 32'h12345678, 32'h0, 2, 1'b0, 4'b0010, 32'h78787878, 32'h0, 4, 1'b0};
        vecs[4]  = '{1'b0, 3'b010, 32'h006, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0};
        vecs[5]  = '{1'b1, 3'b110, 32'h040, 32'hCAFEF00D, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0};
        vecs[6]  = '{1'b0, 3'b010, 32'h040, 32'h0, 32'h13579BDF, 99, 1'b0, 4'b1111, 32'h0, 32'h0, 5, 1'b1};
        vecs[7]  = '{1'b0, 3'b010, 32'h040, 32'h0, 32'hDEADBEEF, 3, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 5, 1'b0};
        vecs[8]  = '{1'b0, 3'b011, 32'h040, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0};
        vecs[9]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 0, 1'b0};
        vecs[10] = '{1'b1, 3'b001, 32'h022, 32'hAAAA5555, 32'h0, 1, 1'b0, 4'b1100, 32'h55555555, 32'h0, 3, 1'b0};
        vecs[11] = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h0000F000, 0, 1'b0, 4'b0010, 32'h0, 32'h000000F0, 2, 1'b0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset pulses", {29'd0, load_valid, misalign, bus_err}, 32'd0);
        chk("reset bus", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            exercise($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
                     vecs[i].wdata, vecs[i].rdata, vecs[i].ack, o);
            chk($sformatf("vec%0d tbl_misalign", i), 32'(o.mis_n), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d tbl_stall", i), 32'(o.stall_n), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d tbl_bus_err", i), 32'(o.be_n), 32'(vecs[i].exp_buserr));
            if (!vecs[i].exp_mis) begin
                chk($sformatf("vec%0d tbl_be", i), 32'(o.be), 32'(vecs[i].exp_be));
                if (vecs[i].we) chk($sformatf("vec%0d tbl_wdata", i), o.wdata, vecs[i].exp_wdata);
                else            chk($sformatf("vec%0d tbl_ld", i), o.lv_data, vecs[i].exp_ld);
            end
        end

        // req_valid held high through DONE is ignored there; next access starts after.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        mem_ack = 1'b0; mem_rdata = 32'h11223344;
        #1 chk("hold c0 stall", 32'(stall), 32'd1);
        @(negedge clk);
        mem_ack = mem_req;
        #1 chk("hold c1 mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("hold done stall", 32'(stall), 32'd0);
        chk("hold done lv", 32'(load_valid), 32'd1);
        chk("hold done data", load_data, 32'h11223344);
        @(negedge clk);
        #1 chk("hold reaccept stall", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        mem_rdata = 32'h55667788;
        mem_ack = mem_req;
        #1 chk("hold 2nd mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("hold 2nd data", load_data, 32'h55667788);
        chk("hold 2nd lv", 32'(load_valid), 32'd1);
        model_ld = 32'h55667788;
        @(negedge clk);

        // Reset in the middle of an outstanding load.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
        mem_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 chk("abort mem_req before", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1 chk("abort mem_req async", 32'(mem_req), 32'd0);
        chk("abort stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_ld = 32'd0;
        n_lv = 0; n_be = 0; n_rq = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (load_valid) n_lv++;
            if (bus_err) n_be++;
            if (mem_req) n_rq++;
        end
        chk("abort no load_valid", 32'(n_lv), 32'd0);
        chk("abort no bus_err", 32'(n_be), 32'd0);
        chk("abort idle", 32'(n_rq), 32'd0);
        exercise("after_reset SW", 1'b1, 3'b010, 32'h44, 32'hA5A5C3C3, 32'h0, 1, o);

        // Randomized accesses against the model.
        for (int i = 0; i < 150; i++) begin
            exercise($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
